estagio_id_ex: RTL

//  ID/EX pipeline stage of the simplified MIPS, directly upstream of the ALU.

---
 rtl/estagio_id_ex.sv | 127 ++++++++++++
 1 files changed

// File: rtl/estagio_id_ex.sv
// ID/EX pipeline register of the simplified MIPS, sitting right before the ALU.
// Captures decoded operands with EX/MEM and MEM/WB forwarding resolved at
// capture time, translates aluop/funct into the 4-bit ALU code, and hands the
// result to the execute stage through a valid/ready handshake with flush.
module estagio_id_ex #(
  parameter int LARGURA   = 32,
  parameter int NREG_BITS = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           aluop,
  input  logic [5:0]           funct,
  input  logic                 alusrc,
  input  logic [NREG_BITS-1:0] rs_idx,
  input  logic [NREG_BITS-1:0] rt_idx,
  input  logic [LARGURA-1:0]   rs_val,
  input  logic [LARGURA-1:0]   rt_val,
  input  logic [LARGURA-1:0]   imm,
  input  logic                 fwd_mem_en,
  input  logic [NREG_BITS-1:0] fwd_mem_reg,
  input  logic [LARGURA-1:0]   fwd_mem_val,
  input  logic                 fwd_wb_en,
  input  logic [NREG_BITS-1:0] fwd_wb_reg,
  input  logic [LARGURA-1:0]   fwd_wb_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           ctrlULA,
  output logic [LARGURA-1:0]   entradaA,
  output logic [LARGURA-1:0]   entradaB,
  output logic                 ilegal
);

  // Operand selection: the younger EX/MEM result wins over MEM/WB; $zero is
  // hard-wired and must never pick up a forwarded value.
  function automatic logic [LARGURA-1:0] forward(
    input logic [NREG_BITS-1:0] idx,
    input logic [LARGURA-1:0]   reg_val
  );
    logic [LARGURA-1:0] sel;
    sel = reg_val;
    if (idx != '0) begin
      if (fwd_mem_en && (fwd_mem_reg == idx))
        sel = fwd_mem_val;
      else if (fwd_wb_en && (fwd_wb_reg == idx))
        sel = fwd_wb_val;
    end
    return sel;
  endfunction

  // ALU control: returns {ilegal, ctrlULA}. Unknown R-type funct maps to 15,
  // which the ALU treats as "produce zero".
  function automatic logic [4:0] decode(
    input logic [1:0] op,
    input logic [5:0] fn
  );
    logic [4:0] r;
    r = {1'b0, 4'd2};
    case (op)
      2'b00: r = {1'b0, 4'd2};
      2'b01: r = {1'b0, 4'd6};
      2'b11: r = {1'b0, 4'd1};
      default: begin
        case (fn)
          6'b100000: r = {1'b0, 4'd2};
          6'b100010: r = {1'b0, 4'd6};
          6'b100100: r = {1'b0, 4'd0};
          6'b100101: r = {1'b0, 4'd1};
          6'b101010: r = {1'b0, 4'd7};
          6'b100111: r = {1'b0, 4'd12};
          default:   r = {1'b1, 4'd15};
        endcase
      end
    endcase
    return r;
  endfunction

  logic               vld_p1;
  logic [3:0]         ctrl_p1;
  logic               ilegal_p1;
  logic [LARGURA-1:0] op_a_p1;
  logic [LARGURA-1:0] op_b_p1;
  logic [4:0]         dec_p0;
  logic [LARGURA-1:0] op_a_p0;
  logic [LARGURA-1:0] op_b_p0;
  logic               accept;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Capture-side combinational decode and forwarding (stage p0)
  always_comb begin
    dec_p0  = decode(aluop, funct);
    op_a_p0 = forward(rs_idx, rs_val);
    op_b_p0 = alusrc ? imm : forward(rt_idx, rt_val);
  end

  // Stage register p0 -> p1: reset clears everything, flush only kills valid
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= '0;
      ilegal_p1 <= 1'b0;
      op_a_p1   <= '0;
      op_b_p1   <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      ctrl_p1   <= dec_p0[3:0];
      ilegal_p1 <= dec_p0[4];
      op_a_p1   <= op_a_p0;
      op_b_p1   <= op_b_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign ctrlULA   = ctrl_p1;
  assign ilegal    = ilegal_p1;
  assign entradaA  = op_a_p1;
  assign entradaB  = op_b_p1;

endmodule
